// File: rtl/mem_pkg.sv
// Shared memory-request definitions: access size encodings, default
// queue/outstanding limits, pending-entry layout and lane helpers.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   localparam int unsigned OUTST_MAX_DEF  = 2;
   localparam int unsigned FIFO_DEPTH_DEF = 2;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } req_entry_t;

   // Byte-lane write strobes; loads never write.
   function automatic logic [3:0] lane_strobe(logic we, logic [1:0] size, logic [1:0] off);
      logic [3:0] s;
      s = '0;
      if (we) begin
         case (size)
            SZ_BYTE: s = 4'b0001 << off;
            SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
         endcase
      end
      return s;
   endfunction

   // Replicate the store value across every lane it could land in.
   function automatic logic [31:0] lane_data(logic [1:0] size, logic [31:0] d);
      logic [31:0] r;
      case (size)
         SZ_BYTE: r = {4{d[7:0]}};
         SZ_HALF: r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_req_fifo.sv
// Pending-request buffer: in-order FIFO of formatted SRAM requests.
// Push is refused when full (no same-cycle pop bypass); pointers wrap
// modulo DEPTH so non power-of-two depths are supported.
module dmem_req_fifo
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  logic       pop_i,
   input  req_entry_t din_i,
   output req_entry_t dout_o,
   output logic       empty_o,
   output logic       full_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OW = $clog2(DEPTH + 1);

   req_entry_t    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          do_push, do_pop;

   assign empty_o = (occ_q == '0);
   assign full_o  = (occ_q == OW'(DEPTH));
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   // Next pointer/occupancy values with modulo-DEPTH wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Pointer and occupancy registers; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Entry storage; contents need no reset since occupancy gates reads.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/dmem_req_gen.sv
// Data-memory request generator: formats load/store requests into SRAM
// strobes/data, buffers them in order and issues them under an
// outstanding-transaction limit.
// Optional macro DMEM_ALE_CHECK_EN: misaligned half/word requests are
// consumed without being queued and raise a one-cycle ale pulse.
module dmem_req_gen
   import mem_pkg::*;
#(
   parameter int unsigned OUTST_MAX  = OUTST_MAX_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_we,
   input  logic [1:0]  in_size,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [31:0] data_sram_addr,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   output logic        busy,
   output logic        ale
);

   localparam int unsigned CW = $clog2(OUTST_MAX + 1);

   req_entry_t    in_entry, head;
   logic          empty, full;
   logic          accept, push, req_ok, issue, retire;
   logic [CW-1:0] cnt_q, cnt_d;

   assign in_ready = !full;
   assign accept   = in_valid && !full;

`ifdef DMEM_ALE_CHECK_EN
   logic misaligned;
   logic ale_q;

   assign misaligned = ((in_size == SZ_HALF) && in_addr[0]) ||
                       ((in_size == SZ_WORD) && (in_addr[1:0] != 2'b00));
   assign push = accept && !misaligned;
   assign ale  = ale_q;

   // One-cycle alignment-error pulse following a rejected acceptance.
   always_ff @(posedge clk) begin
      if (reset) ale_q <= 1'b0;
      else       ale_q <= accept && misaligned;
   end
`else
   assign push = accept;
   assign ale  = 1'b0;
`endif

   assign in_entry = '{wr:    in_we,
                       size:  in_size,
                       addr:  in_addr,
                       wstrb: lane_strobe(in_we, in_size, in_addr[1:0]),
                       wdata: lane_data(in_size, in_wdata)};

   dmem_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (issue),
      .din_i   (in_entry),
      .dout_o  (head),
      .empty_o (empty),
      .full_o  (full)
   );

   assign req_ok = !empty && (cnt_q < CW'(OUTST_MAX));
   assign issue  = req_ok && data_sram_addr_ok;
   assign retire = data_sram_data_ok && (cnt_q != '0);
   assign busy   = !empty || (cnt_q != '0);

   // SRAM request outputs: head entry when queued, all zero when empty.
   always_comb begin
      data_sram_req   = req_ok;
      data_sram_wr    = 1'b0;
      data_sram_size  = '0;
      data_sram_addr  = '0;
      data_sram_wstrb = '0;
      data_sram_wdata = '0;
      if (!empty) begin
         data_sram_wr    = head.wr;
         data_sram_size  = head.size;
         data_sram_addr  = head.addr;
         data_sram_wstrb = head.wstrb;
         data_sram_wdata = head.wdata;
      end
   end

   // Outstanding count: stray data_ok at zero is ignored, so no wrap.
   always_comb begin
      cnt_d = cnt_q;
      case ({issue, retire})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Outstanding-count register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: tb/tb_dmem_req_gen.sv
// Self-checking bench for dmem_req_gen: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_dmem_req_gen;

   localparam int DEPTH = 2;
   localparam int OUTST = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_we;
   logic [1:0]  in_size;
   logic [31:0] in_addr, in_wdata;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic [3:0]  data_sram_wstrb;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic        busy, ale;

   always #5 clk = ~clk;

   dmem_req_gen #(
      .OUTST_MAX  (OUTST),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_we             (in_we),
      .in_size           (in_size),
      .in_addr           (in_addr),
      .in_wdata          (in_wdata),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .busy              (busy),
      .ale               (ale)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } ent_t;

   ent_t mq[$];
   int   mcnt;
   logic m_ale;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   cmp_en = 0;

   // An access of n bytes covers the n-aligned lane group containing addr;
   // lane i carries byte (i mod n) of the store value.
   function automatic ent_t make_ent(logic we, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
      ent_t e;
      int n, base;
      n = 1 << sz;
      base = int'(a[1:0]) & ~(n - 1);
      e.wr = we; e.size = sz; e.addr = a; e.wstrb = '0; e.wdata = '0;
      for (int i = 0; i < 4; i++) begin
         e.wdata[8*i +: 8] = d[8*(i % n) +: 8];
         if (we && i >= base && i < base + n) e.wstrb[i] = 1'b1;
      end
      return e;
   endfunction

   function automatic bit is_misal(logic [1:0] sz, logic [31:0] a);
      return (int'(a[1:0]) % (1 << sz)) != 0;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_update();
      bit acc, iss, ret, mis;
      if (reset) begin
         mq.delete();
         mcnt  = 0;
         m_ale = 1'b0;
         return;
      end
      acc = in_valid && (mq.size() < DEPTH);
      iss = (mq.size() > 0) && (mcnt < OUTST) && data_sram_addr_ok;
      ret = data_sram_data_ok && (mcnt > 0);
`ifdef DMEM_ALE_CHECK_EN
      mis = is_misal(in_size, in_addr);
`else
      mis = 1'b0;
`endif
      if (iss) void'(mq.pop_front());
      if (acc && !mis) mq.push_back(make_ent(in_we, in_size, in_addr, in_wdata));
      mcnt  = mcnt + int'(iss) - int'(ret);
      m_ale = acc && mis;
   endfunction

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      ent_t h;
      bit   e;
      if (cmp_en) begin
         e = (mq.size() == 0);
         chk("in_ready", in_ready, mq.size() < DEPTH);
         chk("req", data_sram_req, !e && (mcnt < OUTST));
         chk("busy", busy, !e || (mcnt != 0));
         chk("ale", ale, m_ale);
         if (e) begin
            h.wr = 1'b0; h.size = '0; h.addr = '0; h.wstrb = '0; h.wdata = '0;
         end else begin
            h = mq[0];
         end
         chk("wr", data_sram_wr, h.wr);
         chk("size", data_sram_size, h.size);
         chk("addr", data_sram_addr, h.addr);
         chk("wstrb", data_sram_wstrb, h.wstrb);
         chk("wdata", data_sram_wdata, h.wdata);
      end
   end

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic flush();
      in_valid = 1'b0;
      data_sram_addr_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (mq.size() == 0 && mcnt == 0) break;
         data_sram_data_ok = (mcnt > 0);
         step();
      end
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      chk("flush_busy", busy, 0);
   endtask

   task automatic offer(logic we, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
      in_valid = 1'b1; in_we = we; in_size = sz; in_addr = a; in_wdata = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_size = '0;
      in_addr = '0; in_wdata = '0;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
      mcnt = 0; m_ale = 1'b0;
      step();
      cmp_en = 1;
      step();
      reset = 1'b0;
      step();
      chk("rst_ready", in_ready, 1);
      chk("rst_req", data_sram_req, 0);
      chk("rst_busy", busy, 0);

      // Byte store at lane 3.
      offer(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5);
      chk("b_req_pre", data_sram_req, 0);
      step();
      in_valid = 1'b0;
      chk("b_req", data_sram_req, 1);
      chk("b_wstrb", data_sram_wstrb, 32'h8);
      chk("b_wdata", data_sram_wdata, 32'hA5A5_A5A5);
      chk("b_wr", data_sram_wr, 1);
      chk("b_addr", data_sram_addr, 32'h1003);
      flush();

      // Half store at upper halfword, then word load.
      offer(1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF);
      step();
      in_valid = 1'b0;
      chk("h_wstrb", data_sram_wstrb, 32'hC);
      chk("h_wdata", data_sram_wdata, 32'hBEEF_BEEF);
      flush();
      offer(1'b0, 2'd2, 32'h0000_3000, 32'hDEAD_BEEF);
      step();
      in_valid = 1'b0;
      chk("l_wstrb", data_sram_wstrb, 0);
      chk("l_wr", data_sram_wr, 0);
      chk("l_addr", data_sram_addr, 32'h3000);
      flush();

      // Backpressure: three offers with addr_ok low.
      offer(1'b1, 2'd2, 32'h0000_4000, 32'h1111_1111);
      step();
      offer(1'b1, 2'd2, 32'h0000_4004, 32'h2222_2222);
      step();
      offer(1'b1, 2'd2, 32'h0000_4008, 32'h3333_3333);
      chk("bp_ready", in_ready, 0);
      chk("bp_head", data_sram_addr, 32'h4000);
      step();
      chk("bp_ready2", in_ready, 0);
      chk("bp_hold", data_sram_addr, 32'h4000);
      chk("bp_hold_wd", data_sram_wdata, 32'h1111_1111);
      in_valid = 1'b0;
      data_sram_addr_ok = 1'b1;
      step();
      chk("bp_order", data_sram_addr, 32'h4004);
      step();
      data_sram_addr_ok = 1'b0;
      chk("bp_drained", data_sram_req, 0);

      // Outstanding limit: two issued, none completed.
      offer(1'b1, 2'd2, 32'h0000_5000, 32'h5555_5555);
      step();
      in_valid = 1'b0;
      chk("ol_req", data_sram_req, 0);
      chk("ol_addr", data_sram_addr, 32'h5000);
      chk("ol_busy", busy, 1);
      data_sram_data_ok = 1'b1;
      step();
      data_sram_data_ok = 1'b0;
      chk("ol_req_back", data_sram_req, 1);
      flush();

      // Reset with two queued and one outstanding.
      offer(1'b1, 2'd2, 32'h0000_6000, 32'h0);
      step();
      offer(1'b1, 2'd2, 32'h0000_6004, 32'h0);
      data_sram_addr_ok = 1'b1;
      step();
      offer(1'b1, 2'd2, 32'h0000_6008, 32'h0);
      data_sram_addr_ok = 1'b0;
      step();
      in_valid = 1'b0;
      chk("r_full", in_ready, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("r_busy", busy, 0);
      chk("r_req", data_sram_req, 0);
      chk("r_ready", in_ready, 1);
      data_sram_data_ok = 1'b1;
      step();
      data_sram_data_ok = 1'b0;
      chk("r_stray", busy, 0);
      offer(1'b1, 2'd2, 32'h0000_6100, 32'h0);
      step();
      in_valid = 1'b0;
      chk("r_cnt_zero", data_sram_req, 1);
      flush();

      // Misaligned word.
      offer(1'b0, 2'd2, 32'h0000_1002, 32'h0);
      step();
      in_valid = 1'b0;
`ifdef DMEM_ALE_CHECK_EN
      chk("ale_hi", ale, 1);
      chk("ale_noreq", data_sram_req, 0);
      step();
      chk("ale_lo", ale, 0);
`else
      chk("ale_off", ale, 0);
      chk("ale_off_req", data_sram_req, 1);
      chk("ale_off_addr", data_sram_addr, 32'h1002);
`endif
      flush();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         reset             = ($urandom_range(0, 199) == 0);
         in_valid          = $urandom_range(0, 1);
         in_we             = $urandom_range(0, 1);
         in_size           = 2'($urandom_range(0, 2));
         in_addr           = $urandom;
         in_wdata          = $urandom;
         data_sram_addr_ok = ($urandom_range(0, 2) != 0);
         data_sram_data_ok = (mcnt > 0) && ($urandom_range(0, 1) == 1);
         step();
      end
      reset = 1'b0;
      flush();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_req_gen.md
DMEM_REQ_GEN -- requirements
Module: dmem_req_gen

Interface
REQ-001 SHALL have parameter OUTST_MAX, default 2, the maximum number of address-accepted requests still awaiting data_ok.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the number of pending-request buffer entries.
REQ-003 SHALL have ports: clk in 1 clock; reset in 1 reset, synchronous, active-high.
REQ-004 SHALL have ports: in_valid in 1 request offered; in_ready out 1 request accepted this cycle when high with in_valid.
REQ-005 SHALL have ports: in_we in 1 store(1)/load(0); in_size in 2 0=byte, 1=half, 2=word; in_addr in 32 byte address; in_wdata in 32 raw register store value.
REQ-006 SHALL have ports: data_sram_req out 1; data_sram_wr out 1; data_sram_size out 2; data_sram_addr out 32; data_sram_wstrb out 4; data_sram_wdata out 32.
REQ-007 SHALL have ports: data_sram_addr_ok in 1 address handshake; data_sram_data_ok in 1 response completion.
REQ-008 SHALL have ports: busy out 1 FIFO non-empty or outstanding count nonzero; ale out 1 one-cycle misaligned-access pulse.

Function
REQ-009 SHALL set in_ready = FIFO not full, with no same-cycle pop bypass when full.
REQ-010 SHALL enqueue on in_valid && in_ready and expose that entry on data_sram_req no earlier than the next cycle.
REQ-011 SHALL set wstrb: byte -> 4'b0001 << addr[1:0]; half -> addr[1] ? 4'b1100 : 4'b0011; word -> 4'b1111; any load -> 4'b0000.
REQ-012 SHALL set wdata: byte -> low byte replicated 4 times; half -> low halfword replicated 2 times; word -> unchanged.
REQ-013 SHALL set data_sram_addr to in_addr unmodified, data_sram_wr to in_we and data_sram_size to in_size.
REQ-014 SHALL assert data_sram_req when the FIFO is non-empty and the outstanding count < OUTST_MAX.
REQ-015 SHALL drive all data_sram_* outputs to 0 when the FIFO is empty.
REQ-016 SHALL pop the head entry on data_sram_req && data_sram_addr_ok.
REQ-017 SHALL update the outstanding count: +1 on addr handshake; -1 on data_ok; unchanged on both in one cycle.
REQ-018 SHALL ignore data_ok when the outstanding count is 0; the count stays 0 with no wrap.
REQ-019 SHALL allow enqueue and pop in the same cycle when not full, with occupancy unchanged.
REQ-020 SHALL preserve FIFO order; pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL hold head outputs stable while data_sram_req is high and addr_ok is low.

Reset
REQ-022 SHALL on reset empty the FIFO, clear the outstanding count, and clear ale; in the next cycle in_ready=1, data_sram_req=0, busy=0.
REQ-023 SHALL on reset mid-operation discard pending entries; data_ok arriving after reset SHALL be ignored per REQ-018.

Configuration
REQ-024 SHALL, with DMEM_ALE_CHECK_EN defined, check alignment on acceptance (half with addr[0]=1, word with addr[1:0]!=0): the request is consumed (in_ready handshake completes), not enqueued, and ale pulses high for one cycle the following cycle.
REQ-025 SHALL, without DMEM_ALE_CHECK_EN, enqueue all requests unchecked with ale tied to 0.

Structure
REQ-026 SHALL place size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and OUTST_MAX/FIFO_DEPTH defaults in shared package mem_pkg.
REQ-027 SHALL implement the pending buffer as sub-module dmem_req_fifo (entry = wr, size, addr, wstrb, wdata).

Verification
REQ-028 SHALL cover byte store: addr=0x1003, size=0, wdata=0x000000A5 -> wstrb=4'b1000, wdata=0xA5A5A5A5, wr=1, req high one cycle later.
REQ-029 SHALL cover half store: addr=0x2002, wdata=0x1234BEEF -> wstrb=4'b1100, wdata=0xBEEFBEEF; load word at 0x3000 -> wstrb=0, wr=0.
REQ-030 SHALL cover backpressure: addr_ok=0 with 3 offers -> two accepted, in_ready=0, head held stable; release addr_ok -> issue in order.
REQ-031 SHALL cover outstanding limit: 2 addr handshakes with no data_ok -> req=0 with FIFO non-empty; one data_ok -> req reasserts next cycle.
REQ-032 SHALL cover reset: reset with 2 entries queued and 1 outstanding -> next cycle busy=0, req=0; a stray data_ok leaves the count at 0.
REQ-033 SHALL cover ale (macro on): word at 0x1002 -> ale=1 for one cycle, no req; macro off -> request issued with addr 0x1002.
